shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Command-driven controller that sequences an N-bit bidirectional shift register: parallel load, logical shift left/right and rotate left/right by a programmable amount, one bit position per clock.
- Accepts one command at a time over a valid/ready handshake and owns the shift register state (q).
- Exposes per-cycle shifter control (enable, direction, serial-in bit) so an external bidirectional shifter can be driven in lock-step, or the sequence can be observed.
- Pulses done when each command completes.

Parameters:
- N, 4, width of the shift register.
- AW, 3, width of the shift-amount field and internal down-counter. Amounts 0..2^AW-1 are legal.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  controller can accept a command. Accept occurs when cmd_valid & cmd_ready at a rising edge.
- cmd_op  input  3  opcode: 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR; 110/111 are treated as NOP.
- cmd_amt  input  AW  number of single-bit steps.
- cmd_fill  input  1  bit inserted at the vacated end for SHL/SHR.
- cmd_data  input  N  parallel value for LOAD.
- q  output  N  current register contents.
- sh_en  output  1  a shift step is applied at the next edge.
- sh_dir  output  1  step direction: 1 = right (toward bit 0), 0 = left.
- sh_in  output  1  bit entering the register on this step.
- out_bit  output  1  last bit shifted or rotated out.
- busy  output  1  command in progress (not IDLE).
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low, immediate, no clock required):
  - q=0, out_bit=0, state=IDLE, counter=0, done=0.
  - busy=0, cmd_ready=1, sh_en=0, sh_dir=0, sh_in=0.
- Reset asserted mid-command aborts it: no done pulse is issued, and the latched command is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On accept, latch op, amt and fill.
  - LOAD: q<=cmd_data at the accept edge; go to DONE.
  - NOP, reserved opcodes, or any shift/rotate with amt=0: q unchanged; go to DONE.
  - Shift/rotate with amt>0: counter<=amt; go to SHIFT.
- SHIFT:
  - cmd_ready=0, busy=1, sh_en=1.
  - Each edge applies exactly one step:
    - SHL: q<={q[N-2:0],fill}, out_bit<=q[N-1].
    - SHR: q<={fill,q[N-1:1]}, out_bit<=q[0].
    - ROL: sh_in=q[N-1]; out_bit<=q[N-1].
    - ROR: sh_in=q[0]; out_bit<=q[0].
  - sh_dir=1 for SHR/ROR, 0 for SHL/ROL.
  - sh_in=fill for SHL/SHR.
  - sh_en, sh_dir and sh_in are combinational from state, latched op and q; they are valid the cycle before the edge that applies the step.
  - counter decrements each edge. When counter==1, the edge applies the final step and the next state is DONE.
- DONE:
  - done=1, busy=1, cmd_ready=0, sh_en=0.
  - Unconditionally returns to IDLE at the next edge.
- Latency: a command accepted at edge E0 with amt=k>0 shifts on edges E1..Ek. done is high between Ek and Ek+1. cmd_ready reasserts after Ek+1. The next accept is possible no earlier than Ek+1.
- Zero-step commands (NOP, LOAD, amt=0): done between E0 and E1; next accept no earlier than E1.
- Amounts >= N are legal:
  - SHL/SHR saturate to all-fill after N steps.
  - Rotate by N returns the original value.
- cmd_valid and all cmd_* inputs are ignored while cmd_ready=0. Input changes during a command do not affect it.
- out_bit holds its value outside SHIFT. LOAD does not modify out_bit.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> q=0000, cmd_ready=1, busy=0, done=0, sh_en=0, out_bit=0.
- LOAD 1010 accepted at E0 -> q=1010 after E0; done=1 for exactly one cycle; cmd_ready=0 during that cycle, 1 afterwards.
- From 1010, SHL amt=2 fill=1:
  - After E1: q=0101, out_bit=1.
  - After E2: q=1011, out_bit=0.
  - sh_en high for exactly 2 cycles with sh_dir=0, sh_in=1; done pulse follows E2.
- From 1011, ROR amt=4:
  - sh_in values over the 4 steps are 1,1,0,1.
  - After E4, q=1011.
  - sh_dir=1 throughout; single done pulse.
- SHR amt=0, then opcode 111, with cmd_valid held high continuously:
  - Each completes with q unchanged and done one cycle after accept.
  - No accept occurs while cmd_ready=0.
- From 1011, SHR amt=3 fill=0; drop rst_n between E1 and E2:
  - q=0000, busy=0, cmd_ready=1 immediately.
  - No done pulse is issued.
  - After release, the next command is accepted normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Command-driven sequencer owning an N-bit shift register: load, shift and rotate, one bit per clock.
// Latency: zero-step commands finish in 1 cycle; amt=k>0 takes k step cycles plus 1 done cycle.
// Backpressure: cmd_ready is high only in IDLE; cmd_* inputs are ignored while it is low.
module shift_sequencer #(
  parameter int N  = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_amt,
  input  logic          cmd_fill,
  input  logic [N-1:0]  cmd_data,
  output logic [N-1:0]  q,
  output logic          sh_en,
  output logic          sh_dir,
  output logic          sh_in,
  output logic          out_bit,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic          fill_q, fill_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  data_q, data_d;
  logic          out_bit_q, out_bit_d;

  logic accept;
  logic cmd_is_step;

  assign accept      = cmd_valid & cmd_ready;
  // Only shift/rotate opcodes with a nonzero amount need the SHIFT state.
  assign cmd_is_step = (cmd_op >= OP_SHL) && (cmd_op <= OP_ROR) && (cmd_amt != '0);

  assign q       = data_q;
  assign out_bit = out_bit_q;

  // State register; reset aborts any command in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the step counter reaching 1 marks the final step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = cmd_is_step ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == AW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: shifter controls are valid the cycle before the edge that applies the step.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    sh_en     = 1'b0;
    sh_dir    = 1'b0;
    sh_in     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_SHIFT: begin
        busy   = 1'b1;
        sh_en  = 1'b1;
        sh_dir = (op_q == OP_SHR) || (op_q == OP_ROR);
        case (op_q)
          OP_ROL:  sh_in = data_q[N-1];
          OP_ROR:  sh_in = data_q[0];
          default: sh_in = fill_q;
        endcase
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next state: command latch on accept, one step per SHIFT cycle driven by the
  // same sh_dir/sh_in an external shifter would see, so both stay in lock-step.
  always_comb begin
    op_d      = op_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    out_bit_d = out_bit_q;
    if (accept) begin
      op_d   = cmd_op;
      fill_d = cmd_fill;
      cnt_d  = cmd_is_step ? cmd_amt : '0;
      if (cmd_op == OP_LOAD) begin
        data_d = cmd_data;
      end
    end else if (sh_en) begin
      cnt_d = cnt_q - AW'(1);
      if (sh_dir) begin
        data_d    = {sh_in, data_q[N-1:1]};
        out_bit_d = data_q[0];
      end else begin
        data_d    = {data_q[N-2:0], sh_in};
        out_bit_d = data_q[N-1];
      end
    end
  end

  // Datapath registers; reset discards the latched command and clears the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      fill_q    <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      out_bit_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      out_bit_q <= out_bit_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: inputs change and outputs are sampled on the falling edge.
module tb_shift_sequencer;

  localparam int N  = 4;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_amt;
  logic          cmd_fill;
  logic [N-1:0]  cmd_data;
  logic [N-1:0]  q;
  logic          sh_en;
  logic          sh_dir;
  logic          sh_in;
  logic          out_bit;
  logic          busy;
  logic          done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  shift_sequencer #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_fill  (cmd_fill),
    .cmd_data  (cmd_data),
    .q         (q),
    .sh_en     (sh_en),
    .sh_dir    (sh_dir),
    .sh_in     (sh_in),
    .out_bit   (out_bit),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [2:0] op, input logic [AW-1:0] amt, input logic fill,
                      input logic [N-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_fill  = fill;
    cmd_data  = data;
  endtask

  initial begin : stim
    logic [3:0] ror_in;
    logic [3:0] ror_q [4];
    int         wait_cyc;

    ror_in   = 4'b1011;  // sh_in per step, bit i = step i: 1,1,0,1
    ror_q[0] = 4'b1101;
    ror_q[1] = 4'b1110;
    ror_q[2] = 4'b0111;
    ror_q[3] = 4'b1011;

    // Reset held with random inputs
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_amt   = AW'($urandom_range(0, 7));
    cmd_fill  = 1'($urandom_range(0, 1));
    cmd_data  = N'($urandom_range(0, 15));
    #1;
    chk("rst_q_immediate", 32'(q), 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_sh_en", 32'(sh_en), 32'h0);
    chk("rst_sh_dir_in", 32'({sh_dir, sh_in}), 32'h0);
    chk("rst_out_bit", 32'(out_bit), 32'h0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 32'({cmd_ready, busy, done}), 32'h4);

    // LOAD 1010
    send(3'b001, 3'd0, 1'b0, 4'b1010);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("load_q", 32'(q), 32'ha);
    chk("load_done", 32'(done), 32'h1);
    chk("load_ready_low", 32'(cmd_ready), 32'h0);
    chk("load_out_bit_kept", 32'(out_bit), 32'h0);
    @(negedge clk);
    chk("load_done_drop", 32'(done), 32'h0);
    chk("load_ready_back", 32'(cmd_ready), 32'h1);

    // SHL amt=2 fill=1 from 1010
    send(3'b010, 3'd2, 1'b1, 4'b0000);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("shl_ctl0", 32'({sh_en, sh_dir, sh_in}), 32'h5);
    chk("shl_q0", 32'(q), 32'ha);
    @(negedge clk);
    chk("shl_q1", 32'(q), 32'h5);
    chk("shl_out1", 32'(out_bit), 32'h1);
    chk("shl_ctl1", 32'({sh_en, sh_dir, sh_in}), 32'h5);
    chk("shl_done1", 32'(done), 32'h0);
    @(negedge clk);
    chk("shl_q2", 32'(q), 32'hb);
    chk("shl_out2", 32'(out_bit), 32'h0);
    chk("shl_en_off", 32'(sh_en), 32'h0);
    chk("shl_done2", 32'(done), 32'h1);
    @(negedge clk);
    chk("shl_done_drop", 32'(done), 32'h0);
    chk("shl_ready_back", 32'(cmd_ready), 32'h1);

    // ROR amt=4 from 1011
    send(3'b101, 3'd4, 1'b0, 4'b0000);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ror_sh_in%0d", i), 32'({sh_en, sh_dir, sh_in}), 32'({2'b11, ror_in[i]}));
      chk($sformatf("ror_done_pre%0d", i), 32'(done), 32'h0);
      @(negedge clk);
      chk($sformatf("ror_q%0d", i), 32'(q), 32'(ror_q[i]));
    end
    chk("ror_done", 32'(done), 32'h1);
    chk("ror_out", 32'(out_bit), 32'h1);
    @(negedge clk);
    chk("ror_done_drop", 32'(done), 32'h0);

    // SHR amt=0 then opcode 111, cmd_valid held high; a LOAD presented while not ready is ignored
    send(3'b011, 3'd0, 1'b1, 4'b0000);
    @(negedge clk);
    chk("shr0_done", 32'(done), 32'h1);
    chk("shr0_q", 32'(q), 32'hb);
    chk("shr0_ready", 32'(cmd_ready), 32'h0);
    send(3'b001, 3'd0, 1'b0, 4'b0000);
    @(negedge clk);
    chk("ignored_load_q", 32'(q), 32'hb);
    chk("ignored_load_done", 32'(done), 32'h0);
    chk("ignored_load_ready", 32'(cmd_ready), 32'h1);
    send(3'b111, 3'd5, 1'b1, 4'b0000);
    @(negedge clk);
    chk("op7_done", 32'(done), 32'h1);
    chk("op7_q", 32'(q), 32'hb);
    chk("op7_no_shift", 32'(sh_en), 32'h0);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("op7_done_drop", 32'(done), 32'h0);

    // SHR amt=3 fill=0 from 1011, reset between E1 and E2
    send(3'b011, 3'd3, 1'b0, 4'b0000);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("shr_ctl0", 32'({sh_en, sh_dir, sh_in}), 32'h6);
    @(negedge clk);
    chk("shr_q1", 32'(q), 32'h5);
    chk("shr_out1", 32'(out_bit), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ready", 32'(cmd_ready), 32'h1);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_out_bit", 32'(out_bit), 32'h0);
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_stays_idle", 32'({busy, done}), 32'h0);
    send(3'b001, 3'd0, 1'b0, 4'b0110);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("post_rst_load_q", 32'(q), 32'h6);
    chk("post_rst_load_done", 32'(done), 32'h1);
    @(negedge clk);

    // SHL amt=5 (> N) fill=0 saturates to 0000; bounded wait for done
    send(3'b010, 3'd5, 1'b0, 4'b0000);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_cyc  = 0;
    while (!done && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("sat_steps", 32'(wait_cyc), 32'd5);
    chk("sat_q", 32'(q), 32'h0);
    chk("sat_out", 32'(out_bit), 32'h0);
    @(negedge clk);

    // ROL amt=4 (= N) returns the original value 0000 -> reload then rotate
    send(3'b001, 3'd0, 1'b0, 4'b1001);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    send(3'b100, 3'd4, 1'b0, 4'b0000);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rol_ctl0", 32'({sh_en, sh_dir, sh_in}), 32'h5);
    @(negedge clk);
    chk("rol_q1", 32'(q), 32'h3);
    chk("rol_out1", 32'(out_bit), 32'h1);
    repeat (3) @(negedge clk);
    chk("rol_q4", 32'(q), 32'h9);
    chk("rol_done", 32'(done), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
